alu_seq: RTL and testbench

Registered, parametrised ALU for the 6809 core that executes the 6809 8/16-bit arithmetic, logic and shift operations in one cycle and the `MUL` operation iteratively, with a start/busy/done handshake.
- Sits between the operand-select muxes and the register file / CC register, replacing the purely combinational 8-bit datapath.
- Instantiated once at `WIDTH=8` for A/B operations and once at `WIDTH=16` for D/X/Y/U/S operations.

---
 rtl/alu_seq.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered 6809 ALU: single-cycle arithmetic/logic/shift ops plus an
// iterative shift-add unsigned multiplier behind a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic               op7,
    input  logic               mul,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               c_in,
    input  logic               v_in,
    input  logic               h_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               c_out,
    output logic               z_out,
    output logic               n_out,
    output logic               v_out,
    output logic               h_out
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS  = ~MSB_ONLY;

    typedef enum logic [0:0] {
        S_IDLE,
        S_MUL
    } state_t;

    typedef enum logic [4:0] {
        OP_NEG, OP_SUB, OP_CMP, OP_SBC, OP_COM,
        OP_LSR, OP_AND, OP_BIT, OP_ROR, OP_LD,
        OP_ASR, OP_ST,  OP_LSL, OP_EOR, OP_ROL,
        OP_ADC, OP_DEC, OP_ORA, OP_ADD, OP_INC,
        OP_TST, OP_CLR, OP_UND
    } alu_op_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 done_q, done_d;
    logic                 c_q, c_d;
    logic                 z_q, z_d;
    logic                 n_q, n_d;
    logic                 v_q, v_d;
    logic                 h_q, h_d;

    alu_op_t              alu_op;
    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       diff_w;
    logic                 add_ci;
    logic                 sub_bi;
    logic [WIDTH-1:0]     alu_r;
    logic                 alu_c;
    logic                 alu_v;
    logic                 alu_h;
    logic                 alu_n;
    logic                 alu_z;
    logic                 alu_upd;
    logic                 lsr_n0;
    logic                 mul_go;
    logic [2*WIDTH-1:0]   mul_sum;

    always_comb begin
        alu_op = OP_UND;
        case (op)
            4'h0:    alu_op = op7 ? OP_SUB : OP_NEG;
            4'h1:    alu_op = op7 ? OP_CMP : OP_UND;
            4'h2:    alu_op = op7 ? OP_SBC : OP_UND;
            4'h3:    alu_op = OP_COM;
            4'h4:    alu_op = op7 ? OP_AND : OP_LSR;
            4'h5:    alu_op = op7 ? OP_BIT : OP_UND;
            4'h6:    alu_op = op7 ? OP_LD  : OP_ROR;
            4'h7:    alu_op = op7 ? OP_ST  : OP_ASR;
            4'h8:    alu_op = op7 ? OP_EOR : OP_LSL;
            4'h9:    alu_op = op7 ? OP_ADC : OP_ROL;
            4'hA:    alu_op = op7 ? OP_ORA : OP_DEC;
            4'hB:    alu_op = op7 ? OP_ADD : OP_UND;
            4'hC:    alu_op = OP_INC;
            4'hD:    alu_op = OP_TST;
            4'hF:    alu_op = OP_CLR;
            default: alu_op = OP_UND;
        endcase
    end

    // Shared adder/subtractor, one bit wider so the top bit is carry/borrow.
    assign add_ci = (alu_op == OP_ADC) & c_in;
    assign sub_bi = (alu_op == OP_SBC) & c_in;
    assign sum_w  = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, add_ci};
    assign diff_w = {1'b0, a_in} - {1'b0, b_in} - {{WIDTH{1'b0}}, sub_bi};

    always_comb begin
        alu_r   = a_in;
        alu_c   = c_in;
        alu_v   = 1'b0;
        alu_h   = h_in;
        alu_upd = 1'b1;
        lsr_n0  = 1'b0;
        case (alu_op)
            OP_NEG: begin
                alu_r = (~a_in) + ONE;
                alu_c = |a_in;
                alu_v = (a_in == MSB_ONLY);
            end
            OP_SUB, OP_CMP, OP_SBC: begin
                alu_r = diff_w[WIDTH-1:0];
                alu_c = diff_w[WIDTH];
                alu_v = (a_in[WIDTH-1] ^ b_in[WIDTH-1]) & (a_in[WIDTH-1] ^ diff_w[WIDTH-1]);
            end
            OP_ADD, OP_ADC: begin
                alu_r = sum_w[WIDTH-1:0];
                alu_c = sum_w[WIDTH];
                alu_v = (a_in[WIDTH-1] ~^ b_in[WIDTH-1]) & (a_in[WIDTH-1] ^ sum_w[WIDTH-1]);
                if (WIDTH == 8) begin
                    alu_h = a_in[4] ^ b_in[4] ^ sum_w[4];
                end
            end
            OP_COM: begin
                alu_r = ~a_in;
                alu_c = 1'b1;
            end
            OP_LSR: begin
                alu_r  = {1'b0, a_in[WIDTH-1:1]};
                alu_c  = a_in[0];
                alu_v  = v_in;
                lsr_n0 = 1'b1;
            end
            OP_ASR: begin
                alu_r = {a_in[WIDTH-1], a_in[WIDTH-1:1]};
                alu_c = a_in[0];
                alu_v = v_in;
            end
            OP_ROR: begin
                alu_r = {c_in, a_in[WIDTH-1:1]};
                alu_c = a_in[0];
                alu_v = v_in;
            end
            // N is the old bit WIDTH-2 and C the old msb, so V = N^C.
            OP_LSL: begin
                alu_r = {a_in[WIDTH-2:0], 1'b0};
                alu_c = a_in[WIDTH-1];
                alu_v = a_in[WIDTH-2] ^ a_in[WIDTH-1];
            end
            OP_ROL: begin
                alu_r = {a_in[WIDTH-2:0], c_in};
                alu_c = a_in[WIDTH-1];
                alu_v = a_in[WIDTH-2] ^ a_in[WIDTH-1];
            end
            OP_AND, OP_BIT: alu_r = a_in & b_in;
            OP_EOR:         alu_r = a_in ^ b_in;
            OP_ORA:         alu_r = a_in | b_in;
            OP_LD:          alu_r = b_in;
            OP_ST, OP_TST:  alu_r = a_in;
            OP_INC: begin
                alu_r = a_in + ONE;
                alu_v = (a_in == MAX_POS);
            end
            OP_DEC: begin
                alu_r = a_in - ONE;
                alu_v = (a_in == MSB_ONLY);
            end
            OP_CLR: begin
                alu_r = '0;
                alu_c = 1'b0;
            end
            default: alu_upd = 1'b0;
        endcase
        alu_n = lsr_n0 ? 1'b0 : alu_r[WIDTH-1];
        alu_z = (alu_r == '0);
    end

    assign mul_go  = (MUL_EN != 0) && mul;
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        c_d      = c_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
        h_d      = h_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mul_go) begin
                        mcand_d  = {{WIDTH{1'b0}}, a_in};
                        mplier_d = b_in;
                        acc_d    = '0;
                        cnt_d    = CNT_INIT;
                        state_d  = S_MUL;
                    end else begin
                        done_d   = 1'b1;
                        result_d = {{WIDTH{1'b0}}, alu_r};
                        if (alu_upd) begin
                            c_d = alu_c;
                            z_d = alu_z;
                            n_d = alu_n;
                            v_d = alu_v;
                            h_d = alu_h;
                        end
                    end
                end
            end
            // N, V and H are left untouched for the whole multiply.
            S_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    result_d = mul_sum;
                    c_d      = mul_sum[WIDTH-1];
                    z_d      = (mul_sum == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            h_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
            c_q      <= c_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
            h_q      <= h_d;
        end
    end

    assign busy   = (state_q == S_MUL);
    assign done   = done_q;
    assign result = result_q;
    assign c_out  = c_q;
    assign z_out  = z_q;
    assign n_out  = n_q;
    assign v_out  = v_q;
    assign h_out  = h_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an 8-bit instance driven from a vector table and
// hand sequences, plus a 16-bit instance for flags, multiply and reset abort.
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        st8, op7_8, mul8, ci8, vi8, hi8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, c8, z8, n8, v8, h8;
    logic [15:0] res8;

    logic        st16, op7_16, mul16, ci16, vi16, hi16;
    logic [3:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, done16, c16, z16, n16, v16, h16;
    logic [31:0] res16;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(8), .MUL_EN(1)) u8 (
        .clk(clk), .reset_n(reset_n), .start(st8), .op(op8), .op7(op7_8), .mul(mul8),
        .a_in(a8), .b_in(b8), .c_in(ci8), .v_in(vi8), .h_in(hi8),
        .busy(busy8), .done(done8), .result(res8),
        .c_out(c8), .z_out(z8), .n_out(n8), .v_out(v8), .h_out(h8)
    );

    alu_seq #(.WIDTH(16), .MUL_EN(1)) u16 (
        .clk(clk), .reset_n(reset_n), .start(st16), .op(op16), .op7(op7_16), .mul(mul16),
        .a_in(a16), .b_in(b16), .c_in(ci16), .v_in(vi16), .h_in(hi16),
        .busy(busy16), .done(done16), .result(res16),
        .c_out(c16), .z_out(z16), .n_out(n16), .v_out(v16), .h_out(h16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // flags packed as {c,z,n,v,h}
    typedef struct {
        logic [3:0]  op;
        logic        op7;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ci, vi, hi;
        logic [15:0] r;
        logic [4:0]  f;
    } vec_t;

    vec_t tbl[22];

    task automatic set8(input logic [3:0] op, input logic o7, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic vi, input logic hi);
        op8 = op; op7_8 = o7; a8 = a; b8 = b; ci8 = ci; vi8 = vi; hi8 = hi;
    endtask

    task automatic mul8_run(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp_r, input logic [4:0] exp_f, input bit poke);
        int nb;
        @(negedge clk);
        st8 = 1'b1; mul8 = 1'b1; a8 = a; b8 = b;
        @(negedge clk);
        st8 = 1'b0; mul8 = 1'b0;
        nb = 0;
        while (busy8 && nb < 20) begin
            nb++;
            if (poke && nb == 3) begin
                st8 = 1'b1; op8 = 4'hF; op7_8 = 1'b1; a8 = 8'h5A;
            end else begin
                st8 = 1'b0;
            end
            @(negedge clk);
        end
        chk({name, " busy cycles"}, 64'(nb), 64'd8);
        chk({name, " out"}, {done8, res8, c8, z8, n8, v8, h8}, {1'b1, exp_r, exp_f});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        int ndone;

        tbl[0]  = '{4'hB, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 16'h0080, 5'b00111}; // ADD
        tbl[1]  = '{4'h0, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 16'h00FF, 5'b10100}; // SUB
        tbl[2]  = '{4'h0, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0080, 5'b10110}; // NEG
        tbl[3]  = '{4'h9, 1'b1, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0010, 5'b00001}; // ADC
        tbl[4]  = '{4'h2, 1'b1, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 16'h007F, 5'b00011}; // SBC
        tbl[5]  = '{4'h1, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 16'h0000, 5'b01000}; // CMP
        tbl[6]  = '{4'h3, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 16'h00AA, 5'b10100}; // COM
        tbl[7]  = '{4'h4, 1'b0, 8'h81, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0040, 5'b10010}; // LSR
        tbl[8]  = '{4'h6, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0081, 5'b00100}; // ROR
        tbl[9]  = '{4'h8, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0080, 5'b00110}; // LSL
        tbl[10] = '{4'h9, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 5'b11010}; // ROL
        tbl[11] = '{4'hA, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, 16'h007F, 5'b10010}; // DEC
        tbl[12] = '{4'hC, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 5'b01000}; // INC
        tbl[13] = '{4'h8, 1'b1, 8'hFF, 8'h0F, 1'b1, 1'b1, 1'b0, 16'h00F0, 5'b10100}; // EOR
        tbl[14] = '{4'hA, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 5'b01000}; // ORA
        tbl[15] = '{4'h5, 1'b1, 8'h80, 8'h81, 1'b0, 1'b0, 1'b0, 16'h0080, 5'b00100}; // BIT
        tbl[16] = '{4'h6, 1'b1, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 5'b11000}; // LD
        tbl[17] = '{4'h7, 1'b1, 8'h90, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0090, 5'b00100}; // ST
        tbl[18] = '{4'hD, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 5'b11000}; // TST
        tbl[19] = '{4'hF, 1'b1, 8'h33, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0000, 5'b01001}; // CLR
        tbl[20] = '{4'hE, 1'b1, 8'h12, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0012, 5'b01001}; // undefined
        tbl[21] = '{4'hB, 1'b0, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0, 16'h0034, 5'b01001}; // undefined

        reset_n = 1'b0;
        st8 = 1'b0; mul8 = 1'b0; set8(4'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        st16 = 1'b0; mul16 = 1'b0; op16 = 4'h0; op7_16 = 1'b0;
        a16 = '0; b16 = '0; ci16 = 1'b0; vi16 = 1'b0; hi16 = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset8", {busy8, done8, res8, c8, z8, n8, v8, h8}, 64'd0);
        chk("reset16", {busy16, done16, res16, c16, z16, n16, v16, h16}, 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            st8 = 1'b1;
            set8(tbl[i].op, tbl[i].op7, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].vi, tbl[i].hi);
            @(negedge clk);
            st8 = 1'b0;
            chk($sformatf("vec%0d", i), {done8, res8, c8, z8, n8, v8, h8}, {1'b1, tbl[i].r, tbl[i].f});
        end
        @(negedge clk);
        chk("done8 one pulse", {done8, res8}, {1'b0, 16'h0034});

        // back-to-back AND then CLR
        st8 = 1'b1; set8(4'h4, 1'b1, 8'hF0, 8'h3C, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("b2b AND", {done8, res8, c8, z8, n8, v8, h8}, {1'b1, 16'h0030, 5'b10000});
        set8(4'hF, 1'b1, 8'h77, 8'h00, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        st8 = 1'b0;
        chk("b2b CLR", {done8, res8, c8, z8, n8, v8, h8}, {1'b1, 16'h0000, 5'b01001});
        @(negedge clk);
        chk("b2b done drops", {done8, busy8}, 2'b00);

        // multiply with an ignored mid-run start; N/V/H keep CLR values
        set8(4'h0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        mul8_run("mul8 FFxFF", 8'hFF, 8'hFF, 16'hFE01, 5'b00001, 1'b1);
        // start in the cycle busy falls is accepted
        st8 = 1'b1; set8(4'hB, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        st8 = 1'b0;
        chk("overlap ADD", {done8, busy8, res8, c8, z8, n8, v8, h8}, {2'b10, 16'h0003, 5'b00000});
        mul8_run("mul8 10x08", 8'h10, 8'h08, 16'h0080, 5'b10000, 1'b0);
        mul8_run("mul8 00x55", 8'h00, 8'h55, 16'h0000, 5'b01000, 1'b0);

        // 16-bit flags
        @(negedge clk);
        st16 = 1'b1; op16 = 4'hC; op7_16 = 1'b0; a16 = 16'h7FFF; ci16 = 1'b1; vi16 = 1'b0; hi16 = 1'b0;
        @(negedge clk);
        st16 = 1'b0;
        chk("inc16", {done16, res16, c16, z16, n16, v16, h16}, {1'b1, 32'h0000_8000, 5'b10110});
        st16 = 1'b1; op16 = 4'h7; op7_16 = 1'b0; a16 = 16'h8001; ci16 = 1'b0; vi16 = 1'b1; hi16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        chk("asr16", {done16, res16, c16, z16, n16, v16, h16}, {1'b1, 32'h0000_C000, 5'b10111});

        // reset in the middle of a 16-bit multiply
        @(negedge clk);
        st16 = 1'b1; mul16 = 1'b1; a16 = 16'h1234; b16 = 16'h5678;
        @(negedge clk);
        st16 = 1'b0; mul16 = 1'b0;
        chk("mul16 busy", {busy16, done16}, 2'b10);
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("reset mid-mul16", {busy16, done16, res16, c16, z16, n16, v16, h16}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done16 || busy16) ndone++;
        end
        chk("no done after abort", 64'(ndone), 64'd0);

        st16 = 1'b1; op16 = 4'hB; op7_16 = 1'b1; a16 = 16'h1234; b16 = 16'h5678;
        ci16 = 1'b1; vi16 = 1'b0; hi16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        chk("add16", {done16, res16, c16, z16, n16, v16, h16}, {1'b1, 32'h0000_68AC, 5'b00001});

        st16 = 1'b1; mul16 = 1'b1; a16 = 16'h1234; b16 = 16'h5678;
        @(negedge clk);
        st16 = 1'b0; mul16 = 1'b0;
        nb = 0;
        while (busy16 && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        chk("mul16 busy cycles", 64'(nb), 64'd16);
        chk("mul16 out", {done16, res16, c16, z16, n16, v16, h16}, {1'b1, 32'h0626_0060, 5'b00001});
        @(negedge clk);
        chk("mul16 hold", {done16, busy16, res16}, {2'b00, 32'h0626_0060});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
